bp_me_wb_burst_master: RTL and testbench

Parametrised successor to the single-beat BedRock-to-Wishbone master adapter. It converts BedRock mem_fwd stream messages (multi-beat, up to a full cache block) into Wishbone B4 pipelined-free incrementing bursts (CTI/BTE driven), and returns BedRock mem_rev responses. It sits between the BP memory-side network and a Wishbone slave (SRAM, peripheral bridge, or bp_me_wb_client loopback).

---
 rtl/bp_me_wb_pkg.sv | 62 ++++++
 rtl/bp_me_wb_burst_gen.sv | 48 ++++
 rtl/bp_me_wb_burst_master.sv | 164 ++++++++++++++++
 tb/tb_bp_me_wb_burst_master.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_me_wb_pkg.sv
// Shared types for the BedRock-to-Wishbone burst master: BedRock header/message
// types, Wishbone CTI/BTE encodings and the adapter state enum.
package bp_me_wb_pkg;

  localparam int unsigned paddr_width_p     = 40;
  localparam int unsigned cce_block_width_p = 512;
  localparam int unsigned payload_width_lp  = 16;

  typedef enum logic [3:0] {
    e_bedrock_mem_rd    = 4'd0,
    e_bedrock_mem_wr    = 4'd1,
    e_bedrock_mem_uc_rd = 4'd2,
    e_bedrock_mem_uc_wr = 4'd3,
    e_bedrock_mem_amo   = 4'd5
  } bp_bedrock_mem_type_e;

  // Size field is log2 of the request size in bytes
  typedef enum logic [2:0] {
    e_bedrock_msg_size_1   = 3'd0,
    e_bedrock_msg_size_2   = 3'd1,
    e_bedrock_msg_size_4   = 3'd2,
    e_bedrock_msg_size_8   = 3'd3,
    e_bedrock_msg_size_16  = 3'd4,
    e_bedrock_msg_size_32  = 3'd5,
    e_bedrock_msg_size_64  = 3'd6,
    e_bedrock_msg_size_128 = 3'd7
  } bp_bedrock_msg_size_e;

  typedef struct packed {
    logic [payload_width_lp-1:0] payload;
    bp_bedrock_msg_size_e        size;
    logic [paddr_width_p-1:0]    addr;
    bp_bedrock_mem_type_e        msg_type;
  } bp_bedrock_mem_fwd_header_s;

  typedef bp_bedrock_mem_fwd_header_s bp_bedrock_mem_rev_header_s;

  localparam int unsigned mem_fwd_header_width_lp = $bits(bp_bedrock_mem_fwd_header_s);
  localparam int unsigned mem_rev_header_width_lp = $bits(bp_bedrock_mem_rev_header_s);

  typedef enum logic [2:0] {
    e_wb_cti_classic = 3'b000,
    e_wb_cti_incr    = 3'b010,
    e_wb_cti_eob     = 3'b111
  } bp_me_wb_cti_e;

  typedef enum logic [1:0] {
    e_wb_bte_linear = 2'b00
  } bp_me_wb_bte_e;

  typedef enum logic [1:0] {
    e_ready   = 2'd0,
    e_write   = 2'd1,
    e_wr_resp = 2'd2,
    e_read    = 2'd3
  } bp_me_wb_state_e;

  function automatic logic is_read(input bp_bedrock_mem_type_e t);
    return (t == e_bedrock_mem_rd) || (t == e_bedrock_mem_uc_rd);
  endfunction

endpackage

// File: rtl/bp_me_wb_burst_gen.sv
// Per-beat Wishbone address, byte select and cycle type derived from the
// captured request size/address and the current beat index.
module bp_me_wb_burst_gen
  import bp_me_wb_pkg::*;
#(
  parameter  int unsigned data_width_p        = 64,
  parameter  int unsigned max_beats_p         = cce_block_width_p / data_width_p,
  localparam int unsigned beat_bytes_lp       = data_width_p / 8,
  localparam int unsigned lg_beat_bytes_lp    = $clog2(beat_bytes_lp),
  localparam int unsigned cnt_width_lp        = (max_beats_p > 1) ? $clog2(max_beats_p) : 1,
  localparam int unsigned wbone_addr_width_lp = paddr_width_p - lg_beat_bytes_lp
) (
  input  bp_bedrock_msg_size_e           size_i,
  input  logic [paddr_width_p-1:0]       addr_i,
  input  logic [cnt_width_lp-1:0]        beat_cnt_i,
  output logic                           oversize_o,
  output logic [wbone_addr_width_lp-1:0] adr_o,
  output logic [beat_bytes_lp-1:0]       sel_o,
  output logic                           last_o,
  output logic [2:0]                     cti_o
);

  int unsigned              size_lg;
  int unsigned              align_lg;
  int unsigned              beats;
  int unsigned              bytes;
  int unsigned              off;
  logic [paddr_width_p-1:0] base;

  always_comb begin
    size_lg    = 32'(size_i);
    align_lg   = (size_lg > lg_beat_bytes_lp) ? size_lg : lg_beat_bytes_lp;
    beats      = (size_lg > lg_beat_bytes_lp) ? (32'd1 << (size_lg - lg_beat_bytes_lp)) : 32'd1;
    bytes      = 32'd1 << size_lg;
    oversize_o = beats > max_beats_p;
    base       = addr_i & ({paddr_width_p{1'b1}} << align_lg);
    adr_o      = wbone_addr_width_lp'(base >> lg_beat_bytes_lp) + wbone_addr_width_lp'(beat_cnt_i);
    // Sub-beat requests select a naturally aligned run of bytes within the beat
    off        = 32'(addr_i[lg_beat_bytes_lp-1:0]) & ~(bytes - 32'd1);
    if (size_lg >= lg_beat_bytes_lp) sel_o = '1;
    else                             sel_o = beat_bytes_lp'(((64'd1 << bytes) - 64'd1) << off);
    last_o     = (32'(beat_cnt_i) == (beats - 32'd1));
    if (beats == 32'd1) cti_o = e_wb_cti_classic;
    else if (last_o)    cti_o = e_wb_cti_eob;
    else                cti_o = e_wb_cti_incr;
  end

endmodule

// File: rtl/bp_me_wb_burst_master.sv
// BedRock mem_fwd/mem_rev to Wishbone B4 incrementing-burst master: one
// outstanding request, header captured on entry and echoed on the response.
module bp_me_wb_burst_master
  import bp_me_wb_pkg::*;
#(
  parameter  int unsigned data_width_p        = 64,
  parameter  int unsigned max_beats_p         = cce_block_width_p / data_width_p,
  localparam int unsigned beat_bytes_lp       = data_width_p / 8,
  localparam int unsigned cnt_width_lp        = (max_beats_p > 1) ? $clog2(max_beats_p) : 1,
  localparam int unsigned wbone_addr_width_lp = paddr_width_p - $clog2(beat_bytes_lp)
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic [mem_fwd_header_width_lp-1:0] mem_fwd_header_i,
  input  logic [data_width_p-1:0]            mem_fwd_data_i,
  input  logic                               mem_fwd_v_i,
  output logic                               mem_fwd_ready_and_o,
  input  logic                               mem_fwd_last_i,
  output logic [mem_rev_header_width_lp-1:0] mem_rev_header_o,
  output logic [data_width_p-1:0]            mem_rev_data_o,
  output logic                               mem_rev_v_o,
  input  logic                               mem_rev_ready_and_i,
  output logic                               mem_rev_last_o,
  output logic [wbone_addr_width_lp-1:0]     adr_o,
  output logic [data_width_p-1:0]            dat_o,
  output logic                               cyc_o,
  output logic                               stb_o,
  output logic [beat_bytes_lp-1:0]           sel_o,
  output logic                               we_o,
  output logic [2:0]                         cti_o,
  output logic [1:0]                         bte_o,
  input  logic [data_width_p-1:0]            dat_i,
  input  logic                               ack_i
);

  bp_me_wb_state_e            state_q, state_d;
  bp_bedrock_mem_fwd_header_s hdr_q, hdr_d, fwd_hdr;
  logic [cnt_width_lp-1:0]    beat_cnt_q, beat_cnt_d;
  logic                       cyc_q, cyc_d;
  logic                       we_q, we_d;
  logic                       last_beat;
  logic                       oversize;

  assign fwd_hdr = bp_bedrock_mem_fwd_header_s'(mem_fwd_header_i);

  bp_me_wb_burst_gen #(
    .data_width_p (data_width_p),
    .max_beats_p  (max_beats_p)
  ) burst_gen (
    .size_i     (hdr_q.size),
    .addr_i     (hdr_q.addr),
    .beat_cnt_i (beat_cnt_q),
    .oversize_o (oversize),
    .adr_o      (adr_o),
    .sel_o      (sel_o),
    .last_o     (last_beat),
    .cti_o      (cti_o)
  );

  // Handshake signals that must react within the cycle come straight from state
  always_comb begin
    state_d             = state_q;
    hdr_d               = hdr_q;
    beat_cnt_d          = beat_cnt_q;
    cyc_d               = cyc_q;
    we_d                = we_q;
    stb_o               = 1'b0;
    mem_fwd_ready_and_o = 1'b0;
    mem_rev_v_o         = 1'b0;
    mem_rev_last_o      = 1'b0;
    mem_rev_data_o      = '0;
    unique case (state_q)
      e_ready: begin
        if (mem_fwd_v_i) begin
          hdr_d      = fwd_hdr;
          beat_cnt_d = '0;
          cyc_d      = 1'b1;
          if (is_read(fwd_hdr.msg_type)) begin
            mem_fwd_ready_and_o = 1'b1;
            we_d                = 1'b0;
            state_d             = e_read;
          end else begin
            // Write beats stay in the fwd stream until the slave acks them
            we_d    = 1'b1;
            state_d = e_write;
          end
        end
      end
      e_write: begin
        stb_o               = mem_fwd_v_i;
        mem_fwd_ready_and_o = ack_i;
        if (ack_i) begin
          beat_cnt_d = beat_cnt_q + cnt_width_lp'(1);
          if (last_beat) begin
            beat_cnt_d = '0;
            cyc_d      = 1'b0;
            we_d       = 1'b0;
            state_d    = e_wr_resp;
          end
        end
      end
      e_wr_resp: begin
        mem_rev_v_o    = 1'b1;
        mem_rev_last_o = 1'b1;
        if (mem_rev_ready_and_i) state_d = e_ready;
      end
      e_read: begin
        // Strobe only when the response can be taken, so read data never needs buffering
        stb_o          = mem_rev_ready_and_i;
        mem_rev_v_o    = ack_i;
        mem_rev_data_o = dat_i;
        mem_rev_last_o = last_beat;
        if (ack_i) begin
          beat_cnt_d = beat_cnt_q + cnt_width_lp'(1);
          if (last_beat) begin
            beat_cnt_d = '0;
            cyc_d      = 1'b0;
            state_d    = e_ready;
          end
        end
      end
      default: state_d = e_ready;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= e_ready;
      hdr_q      <= '0;
      beat_cnt_q <= '0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      hdr_q      <= hdr_d;
      beat_cnt_q <= beat_cnt_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
    end
  end

  assign cyc_o            = cyc_q;
  assign we_o             = we_q;
  assign dat_o            = mem_fwd_data_i;
  assign bte_o            = e_wb_bte_linear;
  assign mem_rev_header_o = hdr_q;

  a_ack_has_stb: assert property (@(posedge clk_i) disable iff (reset_i)
    ack_i |-> (cyc_o && stb_o)) else $error("slave ack without strobe");

  a_wr_last: assert property (@(posedge clk_i) disable iff (reset_i)
    (state_q == e_write && ack_i && last_beat) |-> mem_fwd_last_i)
    else $error("final write beat not marked last");

  a_burst_len: assert property (@(posedge clk_i) disable iff (reset_i)
    (state_q != e_ready) |-> !oversize) else $error("request exceeds max burst length");

  a_msg_type: assert property (@(posedge clk_i) disable iff (reset_i)
    (state_q == e_ready && mem_fwd_v_i) |->
      (fwd_hdr.msg_type inside {e_bedrock_mem_rd, e_bedrock_mem_wr,
                                e_bedrock_mem_uc_rd, e_bedrock_mem_uc_wr}))
    else $error("unsupported mem_fwd message type");

endmodule

// File: tb/tb_bp_me_wb_burst_master.sv
// Randomized bench for bp_me_wb_burst_master: a zero-latency Wishbone slave with
// random wait states, compared against a transaction-level memory model.
module tb_bp_me_wb_burst_master;
  import bp_me_wb_pkg::*;

  localparam int unsigned aw = paddr_width_p - 3;

  logic                               clk;
  logic                               reset_i;
  logic [mem_fwd_header_width_lp-1:0] mem_fwd_header_i;
  logic [63:0]                        mem_fwd_data_i;
  logic                               mem_fwd_v_i;
  logic                               mem_fwd_ready_and_o;
  logic                               mem_fwd_last_i;
  logic [mem_rev_header_width_lp-1:0] mem_rev_header_o;
  logic [63:0]                        mem_rev_data_o;
  logic                               mem_rev_v_o;
  logic                               mem_rev_ready_and_i;
  logic                               mem_rev_last_o;
  logic [aw-1:0]                      adr_o;
  logic [63:0]                        dat_o;
  logic                               cyc_o, stb_o, we_o, ack_i;
  logic [7:0]                         sel_o;
  logic [2:0]                         cti_o;
  logic [1:0]                         bte_o;
  logic [63:0]                        dat_i;

  logic        ack_en;
  logic        mem_init;
  logic [63:0] slv_mem [256];
  logic [63:0] ref_mem [256];

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  bp_me_wb_burst_master #(.data_width_p(64)) dut (
    .clk_i               (clk),
    .reset_i             (reset_i),
    .mem_fwd_header_i    (mem_fwd_header_i),
    .mem_fwd_data_i      (mem_fwd_data_i),
    .mem_fwd_v_i         (mem_fwd_v_i),
    .mem_fwd_ready_and_o (mem_fwd_ready_and_o),
    .mem_fwd_last_i      (mem_fwd_last_i),
    .mem_rev_header_o    (mem_rev_header_o),
    .mem_rev_data_o      (mem_rev_data_o),
    .mem_rev_v_o         (mem_rev_v_o),
    .mem_rev_ready_and_i (mem_rev_ready_and_i),
    .mem_rev_last_o      (mem_rev_last_o),
    .adr_o               (adr_o),
    .dat_o               (dat_o),
    .cyc_o               (cyc_o),
    .stb_o               (stb_o),
    .sel_o               (sel_o),
    .we_o                (we_o),
    .cti_o               (cti_o),
    .bte_o               (bte_o),
    .dat_i               (dat_i),
    .ack_i               (ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] init_word(input int unsigned i);
    return {32'hC0DE0000 | 32'(i), 32'(i) * 32'h01010101};
  endfunction

  // Slave: combinational ack while strobed, writes merged by byte select
  assign ack_i = cyc_o & stb_o & ack_en;
  assign dat_i = slv_mem[adr_o[7:0]];

  always @(posedge clk) begin : slave
    logic [63:0] w;
    if (mem_init) begin
      for (int i = 0; i < 256; i++) slv_mem[i] <= init_word(32'(i));
    end else if (ack_i && we_o) begin
      w = slv_mem[adr_o[7:0]];
      for (int b = 0; b < 8; b++) if (sel_o[b]) w[b*8 +: 8] = dat_o[b*8 +: 8];
      slv_mem[adr_o[7:0]] <= w;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: word address of beat k, aligned to max(request, beat)
  function automatic longint unsigned exp_adr(input longint unsigned addr, input int unsigned sz,
                                              input int unsigned k);
    longint unsigned bytes, align;
    bytes = 64'd1 << sz;
    align = (bytes > 64'd8) ? bytes : 64'd8;
    return (addr - (addr % align)) / 64'd8 + 64'(k);
  endfunction

  function automatic logic [7:0] exp_sel(input longint unsigned addr, input int unsigned sz);
    int unsigned bytes, lo;
    logic [7:0]  s;
    bytes = 32'd1 << sz;
    s = '0;
    if (bytes >= 8) return 8'hFF;
    lo = 32'(addr % 64'd8);
    lo = lo - (lo % bytes);
    for (int unsigned b = 0; b < 8; b++) s[b] = (b >= lo) && (b < lo + bytes);
    return s;
  endfunction

  task automatic run_txn(input bp_bedrock_mem_type_e mt, input int unsigned sz,
                         input longint unsigned addr, input int unsigned v_mode,
                         input int unsigned r_mode, input int abort_at);
    bp_bedrock_mem_fwd_header_s h;
    logic [63:0]     wdata [8];
    logic [7:0]      sl;
    longint unsigned a;
    int unsigned     n, fwd_k, wb_k, cycles, s3, s4, idx;
    bit              is_rd, done, first, ack_now, fwd_hs;
    is_rd  = (mt == e_bedrock_mem_rd) || (mt == e_bedrock_mem_uc_rd);
    n      = (sz > 3) ? (32'd1 << (sz - 3)) : 32'd1;
    fwd_k  = 0; wb_k = 0; cycles = 0; s3 = 0; s4 = 0;
    done   = 1'b0; first = 1'b1;
    h.msg_type = mt;
    h.size     = bp_bedrock_msg_size_e'(3'(sz));
    h.addr     = 40'(addr);
    h.payload  = 16'($urandom);
    for (int i = 0; i < 8; i++) wdata[i] = {$urandom, $urandom};
    mem_fwd_header_i    = h;
    mem_fwd_v_i         = 1'b1;
    mem_fwd_data_i      = wdata[0];
    mem_fwd_last_i      = is_rd || (n == 1);
    mem_rev_ready_and_i = (r_mode == 2) ? 1'($urandom) : 1'b1;
    ack_en              = ($urandom_range(0, 3) != 0);
    while (!done && cycles < 300) begin
      @(negedge clk);
      cycles++;
      ack_now = ack_i;
      fwd_hs  = mem_fwd_v_i && mem_fwd_ready_and_o;
      if (first) begin
        check("fwd_ready_idle", 128'(mem_fwd_ready_and_o), 128'(is_rd));
      end else if (wb_k < n) begin
        check("cyc", 128'(cyc_o), 128'(1'b1));
        check("stb", 128'(stb_o), 128'(is_rd ? mem_rev_ready_and_i : mem_fwd_v_i));
        if (!is_rd) check("rev_v_early", 128'(mem_rev_v_o), 128'(1'b0));
        if (ack_now) begin
          a   = exp_adr(addr, sz, wb_k);
          idx = 32'(a % 64'd256);
          sl  = exp_sel(addr, sz);
          check($sformatf("adr[%0d]", wb_k), 128'(adr_o), 128'(a));
          check($sformatf("sel[%0d]", wb_k), 128'(sel_o), 128'(sl));
          check($sformatf("cti[%0d]", wb_k), 128'(cti_o),
                128'((n == 1) ? 3'b000 : ((wb_k == n - 1) ? 3'b111 : 3'b010)));
          check("we", 128'(we_o), 128'(!is_rd));
          if (is_rd) begin
            check("rd_rev_v", 128'(mem_rev_v_o), 128'(1'b1));
            check($sformatf("rd_data[%0d]", wb_k), 128'(mem_rev_data_o), 128'(ref_mem[idx]));
            check($sformatf("rd_last[%0d]", wb_k), 128'(mem_rev_last_o), 128'(wb_k == n - 1));
            if (wb_k == n - 1) check("rd_hdr", 128'(mem_rev_header_o), 128'(h));
          end else begin
            check($sformatf("wr_dat[%0d]", wb_k), 128'(dat_o), 128'(wdata[wb_k]));
            for (int b = 0; b < 8; b++) if (sl[b]) ref_mem[idx][b*8 +: 8] = wdata[wb_k][b*8 +: 8];
          end
        end
      end else begin
        check("wr_resp_cyc", 128'(cyc_o), 128'(1'b0));
        check("wr_resp_v", 128'(mem_rev_v_o), 128'(1'b1));
        if (mem_rev_ready_and_i) begin
          check("wr_resp_data", 128'(mem_rev_data_o), 128'(0));
          check("wr_resp_last", 128'(mem_rev_last_o), 128'(1'b1));
          check("wr_resp_hdr", 128'(mem_rev_header_o), 128'(h));
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
      first = 1'b0;
      if (ack_now) wb_k++;
      if (fwd_hs) fwd_k++;
      if (is_rd && wb_k == n) done = 1'b1;
      if (!is_rd) begin
        if (fwd_k < n) begin
          if (fwd_hs || !mem_fwd_v_i) begin
            if (v_mode == 0)      mem_fwd_v_i = 1'b1;
            else if (v_mode == 1) mem_fwd_v_i = !fwd_hs;
            else                  mem_fwd_v_i = 1'($urandom);
            mem_fwd_data_i = wdata[fwd_k];
            mem_fwd_last_i = (fwd_k == n - 1);
          end
        end else begin
          mem_fwd_v_i    = 1'b0;
          mem_fwd_last_i = 1'b0;
        end
      end else begin
        mem_fwd_v_i = 1'b0;
      end
      if (r_mode == 1) begin
        mem_rev_ready_and_i = 1'b1;
        if (wb_k == 3 && s3 < 2) begin mem_rev_ready_and_i = 1'b0; s3++; end
        if (wb_k == 4 && s4 < 2) begin mem_rev_ready_and_i = 1'b0; s4++; end
      end else if (r_mode == 2) begin
        mem_rev_ready_and_i = 1'($urandom);
      end else begin
        mem_rev_ready_and_i = 1'b1;
      end
      ack_en = ($urandom_range(0, 3) != 0);
      // Mid-burst reset: bus released at once, no response ever appears
      if (abort_at >= 0 && !done && wb_k == 32'(abort_at)) begin
        check("pre_rst_stb", 128'(stb_o), 128'(mem_fwd_v_i));
        reset_i = 1'b1;
        #1;
        check("rst_cyc", 128'(cyc_o), 128'(1'b0));
        check("rst_stb", 128'(stb_o), 128'(1'b0));
        mem_fwd_v_i    = 1'b0;
        mem_fwd_last_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("rst_no_rev", 128'(mem_rev_v_o), 128'(1'b0));
        end
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        return;
      end
    end
    check("txn_done", 128'(done), 128'(1'b1));
    mem_fwd_v_i    = 1'b0;
    mem_fwd_last_i = 1'b0;
  endtask

  initial begin
    bp_bedrock_mem_type_e mt;
    reset_i             = 1'b1;
    mem_init            = 1'b1;
    mem_fwd_header_i    = '0;
    mem_fwd_data_i      = '0;
    mem_fwd_v_i         = 1'b0;
    mem_fwd_last_i      = 1'b0;
    mem_rev_ready_and_i = 1'b0;
    ack_en              = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(32'(i));
    repeat (3) @(posedge clk);
    #1;
    mem_init = 1'b0;
    @(negedge clk);
    check("rst_cyc_o", 128'(cyc_o), 128'(1'b0));
    check("rst_stb_o", 128'(stb_o), 128'(1'b0));
    check("rst_we_o", 128'(we_o), 128'(1'b0));
    check("rst_fwd_ready", 128'(mem_fwd_ready_and_o), 128'(1'b0));
    check("rst_rev_v", 128'(mem_rev_v_o), 128'(1'b0));
    check("rst_rev_hdr", 128'(mem_rev_header_o), 128'(0));
    @(posedge clk);
    #1;
    reset_i = 1'b0;

    run_txn(e_bedrock_mem_uc_rd, 3, 64'h8000_0010, 0, 0, -1);
    run_txn(e_bedrock_mem_rd,    6, 64'h8000_0040, 0, 0, -1);
    run_txn(e_bedrock_mem_wr,    6, 64'h8000_0080, 1, 0, -1);
    run_txn(e_bedrock_mem_uc_wr, 1, 64'h8000_0006, 0, 0, -1);
    run_txn(e_bedrock_mem_rd,    6, 64'h8000_0080, 0, 1, -1);
    run_txn(e_bedrock_mem_uc_rd, 3, 64'h8000_0000, 0, 0, -1);
    run_txn(e_bedrock_mem_wr,    6, 64'h8000_00C0, 0, 0, 4);
    run_txn(e_bedrock_mem_rd,    6, 64'h8000_00C0, 0, 0, -1);

    for (int t = 0; t < 40; t++) begin
      mt = bp_bedrock_mem_type_e'(4'($urandom_range(0, 3)));
      run_txn(mt, $urandom_range(0, 6), 64'h8000_0000 + 64'($urandom_range(0, 2047)),
              $urandom_range(0, 2), $urandom_range(0, 2), -1);
    end

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
